sort_flow_controller: RTL and testbench

- Replaces hand-timed bench sequencing with a hardware scheduler for the full sort path.
- Slices a 4096-bit block into 8 batches of 16x32-bit words and feeds them one at a time to the 16-input SortingNetwork.
- Routes each sorted batch to exactly one of the 8 InputModules via a one-hot enable, then dequeues the MergeSorterTree until all words have been emitted.

---
 rtl/sort_pkg.sv | 40 ++++
 rtl/sort_ctrl_timer.sv | 29 ++
 rtl/sort_flow_controller.sv | 171 +++++++++++++++++
 tb/tb_sort_flow_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared constants, state encoding and control payload for the sort path.
package sort_pkg;

    localparam int unsigned NWAY        = 8;
    localparam int unsigned WORD        = 32;
    localparam int unsigned BATCH       = 16;
    localparam int unsigned SN_LATENCY  = 12;
    localparam int unsigned FEED_CYCLES = 16;
    localparam int unsigned TOTAL       = NWAY * BATCH;
    localparam int unsigned SLICE_W     = BATCH * WORD;
    localparam int unsigned DIN_W       = NWAY * SLICE_W;
    localparam int unsigned WAY_W       = $clog2(NWAY);
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TIMER_W     =
        $clog2((SN_LATENCY > FEED_CYCLES) ? SN_LATENCY : FEED_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Registered control outputs other than the batch data
    typedef struct packed {
        logic              s_ena;
        logic [NWAY-1:0]   im_ena;
        logic              t_deq;
        logic [WAY_W-1:0]  way;
        logic              busy;
        logic              done;
    } ctrl_t;

    // One-hot InputModule select for a batch index
    function automatic logic [NWAY-1:0] way_onehot(input logic [WAY_W-1:0] w);
        return NWAY'(1) << w;
    endfunction

endpackage

// File: rtl/sort_ctrl_timer.sv
// Loadable down-counter that parks at zero; used for the LOAD/FEED phase timing.
module sort_ctrl_timer
    import sort_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic               zero_c
);

    logic [TIMER_W-1:0] count;

    // Load wins over decrement; decrement saturates at zero
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/sort_flow_controller.sv
// Schedules one 4096-bit block through the sorting network, the InputModules
// and the merge tree: load batch, wait for network, feed one way, repeat, drain.
module sort_flow_controller
    import sort_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DIN_W-1:0]   din,
    input  logic               s_valid,
    input  logic [CNT_W-1:0]   out_cnt,
    output logic [SLICE_W-1:0] s_din,
    output logic               s_ena,
    output logic [NWAY-1:0]    im_ena,
    output logic               t_deq,
    output logic [WAY_W-1:0]   way,
    output logic               busy,
    output logic               done
);

    state_t               state;
    state_t               state_nxt;
    ctrl_t                ctrl;
    ctrl_t                ctrl_nxt;
    logic [SLICE_W-1:0]   s_din_nxt;
    logic [SLICE_W-1:0]   batch [NWAY];

    logic                 tmr_load;
    logic [TIMER_W-1:0]   tmr_load_val;
    logic                 tmr_dec;
    logic                 tmr_clr;
    logic                 tmr_zero_c;

    logic                 last_way_c;
    logic                 drained_c;
    logic                 abort_c;

    assign last_way_c = (ctrl.way == WAY_W'(NWAY - 1));
    assign drained_c  = (out_cnt >= CNT_W'(TOTAL));
    assign abort_c    = abort && (state != IDLE);

    // Batch k is taken from the MSB end of din downwards
    always_comb begin
        for (int unsigned k = 0; k < NWAY; k++) begin
            batch[k] = din[DIN_W - 1 - SLICE_W * k -: SLICE_W];
        end
    end

    sort_ctrl_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero_c   (tmr_zero_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)                   state_nxt = LOAD;
            LOAD:    if (tmr_zero_c && s_valid)   state_nxt = FEED;
            FEED:    if (tmr_zero_c)              state_nxt = last_way_c ? DRAIN : LOAD;
            DRAIN:   if (drained_c)               state_nxt = DONE;
            DONE:    if (!start)                  state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
        if (abort_c) begin
            state_nxt = IDLE;
        end
    end

    // Next values of the registered outputs and timer controls
    always_comb begin
        ctrl_nxt     = ctrl;
        s_din_nxt    = s_din;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        tmr_clr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    ctrl_nxt       = '0;
                    ctrl_nxt.s_ena = 1'b1;
                    ctrl_nxt.busy  = 1'b1;
                    s_din_nxt      = batch[0];
                    tmr_load       = 1'b1;
                    tmr_load_val   = TIMER_W'(SN_LATENCY - 1);
                end
            end
            LOAD: begin
                if (tmr_zero_c && s_valid) begin
                    ctrl_nxt.im_ena = way_onehot(ctrl.way);
                    tmr_load        = 1'b1;
                    tmr_load_val    = TIMER_W'(FEED_CYCLES - 1);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            FEED: begin
                if (tmr_zero_c) begin
                    ctrl_nxt.im_ena = '0;
                    if (last_way_c) begin
                        ctrl_nxt.s_ena = 1'b0;
                        ctrl_nxt.t_deq = 1'b1;
                    end else begin
                        ctrl_nxt.way = ctrl.way + WAY_W'(1);
                        s_din_nxt    = batch[ctrl.way + WAY_W'(1)];
                        tmr_load     = 1'b1;
                        tmr_load_val = TIMER_W'(SN_LATENCY - 1);
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DRAIN: begin
                if (drained_c) begin
                    ctrl_nxt.t_deq = 1'b0;
                    ctrl_nxt.busy  = 1'b0;
                    ctrl_nxt.done  = 1'b1;
                end
            end
            DONE: begin
                if (!start) begin
                    ctrl_nxt.done = 1'b0;
                end
            end
            default: begin
                ctrl_nxt  = '0;
                s_din_nxt = '0;
            end
        endcase
        if (abort_c) begin
            ctrl_nxt  = '0;
            s_din_nxt = '0;
            tmr_clr   = 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl  <= '0;
            s_din <= '0;
        end else begin
            ctrl  <= ctrl_nxt;
            s_din <= s_din_nxt;
        end
    end

    assign s_ena  = ctrl.s_ena;
    assign im_ena = ctrl.im_ena;
    assign t_deq  = ctrl.t_deq;
    assign way    = ctrl.way;
    assign busy   = ctrl.busy;
    assign done   = ctrl.done;

endmodule

// File: tb/tb_sort_flow_controller.sv
// Scenario bench for sort_flow_controller: expected per-way feed events are
// queued when a run starts and popped as the controller raises im_ena.
module tb_sort_flow_controller;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [4095:0] din;
    logic          s_valid;
    logic [7:0]    out_cnt;
    logic [511:0]  s_din;
    logic          s_ena;
    logic [7:0]    im_ena;
    logic          t_deq;
    logic [2:0]    way;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] words [128];

    typedef struct {
        logic [7:0]   im;
        logic [511:0] data;
        int           lat;
    } exp_t;

    exp_t sb [$];

    sort_flow_controller dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .din     (din),
        .s_valid (s_valid),
        .out_cnt (out_cnt),
        .s_din   (s_din),
        .s_ena   (s_ena),
        .im_ena  (im_ena),
        .t_deq   (t_deq),
        .way     (way),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Word 0 is the most significant word of din
    task automatic fill_din();
        for (int i = 0; i < 128; i++) begin
            words[i] = $urandom;
            din[4095 - 32 * i -: 32] = words[i];
        end
    endtask

    function automatic logic [511:0] exp_batch(input int k);
        logic [511:0] b;
        for (int j = 0; j < 16; j++) begin
            b[511 - 32 * j -: 32] = words[16 * k + j];
        end
        return b;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b1; out_cnt = 8'd0;
        din = '0;
        step(); step();
        checks++;
        if ({s_ena, im_ena, t_deq, way, busy, done} !== 15'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %h want 0", {s_ena, im_ena, t_deq, way, busy, done});
        end
        checks++;
        if (s_din !== 512'd0) begin
            failures++;
            $display("FAIL reset_s_din: got %h want 0", s_din);
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    // Full run with optional s_valid stall on one way; start stays high to the end
    task automatic test_sort_run(input int stall_way, input int stall_len, input logic [7:0] final_cnt);
        exp_t e;
        int t0, t_load, t_im, guard, stall_left, lat;
        logic [7:0] prev_im;
        logic [2:0] prev_way;
        fill_din();
        out_cnt = 8'd0;
        s_valid = 1'b1;
        sb.delete();
        for (int k = 0; k < 8; k++) begin
            e.im   = 8'd1 << k;
            e.data = exp_batch(k);
            e.lat  = 12 + ((k == stall_way) ? stall_len : 0);
            sb.push_back(e);
        end
        start = 1'b1;
        step();
        t0 = cyc;
        checks++;
        if (s_din !== exp_batch(0)) begin
            failures++;
            $display("FAIL run_first_s_din: got %h want %h", s_din, exp_batch(0));
        end
        checks++;
        if ({s_ena, busy, way, im_ena, t_deq, done} !== {1'b1, 1'b1, 3'd0, 8'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL run_first_ctrl: got %h want %h", {s_ena, busy, way, im_ena, t_deq, done},
                     {1'b1, 1'b1, 3'd0, 8'd0, 1'b0, 1'b0});
        end
        t_load = cyc; t_im = cyc; prev_im = 8'd0; prev_way = 3'd0; guard = 0; stall_left = 0;
        while (!t_deq && guard < 600) begin
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) s_valid = 1'b1;
            end
            step();
            guard++;
            if (way !== prev_way) begin
                t_load   = cyc;
                prev_way = way;
                if (int'(way) == stall_way && stall_len > 0) begin
                    s_valid    = 1'b0;
                    stall_left = 12 + stall_len;
                end
            end
            if (im_ena != 8'd0 && prev_im == 8'd0) begin
                t_im = cyc;
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL run_extra_feed: got im_ena %h want none", im_ena);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - t_load;
                    checks++;
                    if (im_ena !== e.im) begin
                        failures++;
                        $display("FAIL run_im_ena: got %h want %h", im_ena, e.im);
                    end
                    checks++;
                    if (s_din !== e.data) begin
                        failures++;
                        $display("FAIL run_s_din_way%0d: got %h want %h", way, s_din, e.data);
                    end
                    checks++;
                    if (lat != e.lat) begin
                        failures++;
                        $display("FAIL run_load_latency: got %0d want %0d", lat, e.lat);
                    end
                    checks++;
                    if (s_ena !== 1'b1) begin
                        failures++;
                        $display("FAIL run_s_ena_feed: got %b want 1", s_ena);
                    end
                end
            end
            if (im_ena == 8'd0 && prev_im != 8'd0) begin
                checks++;
                if (cyc - t_im != 16) begin
                    failures++;
                    $display("FAIL run_feed_len: got %0d want 16", cyc - t_im);
                end
            end
            prev_im = im_ena;
        end
        checks++;
        if (t_deq !== 1'b1 || (cyc - t0) != 224 + stall_len) begin
            failures++;
            $display("FAIL run_drain_entry: got t_deq=%b at %0d want 1 at %0d", t_deq, cyc - t0, 224 + stall_len);
        end
        checks++;
        if ({s_ena, im_ena, busy, sb.size() == 0} !== {1'b0, 8'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL run_drain_ctrl: got s_ena=%b im=%h busy=%b pending=%0d want 0 00 1 0",
                     s_ena, im_ena, busy, sb.size());
        end
        for (int n = 1; n <= 128; n++) begin
            out_cnt = (n == 128) ? final_cnt : 8'(n);
            step();
            checks++;
            if (n < 128) begin
                if ({t_deq, done, busy} !== 3'b101) begin
                    failures++;
                    $display("FAIL drain_hold cnt=%0d: got %b want 101", n, {t_deq, done, busy});
                end
            end else if ({t_deq, done, busy} !== 3'b010) begin
                failures++;
                $display("FAIL drain_done cnt=%0d: got %b want 010", final_cnt, {t_deq, done, busy});
            end
        end
    endtask

    task automatic test_start_held();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({done, busy, s_ena} !== 3'b100) begin
                failures++;
                $display("FAIL held_done: got %b want 100", {done, busy, s_ena});
            end
        end
        start = 1'b0;
        step();
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL held_release: got %b want 00", {done, busy});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, s_ena, way, done} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL held_restart: got %b want 11 000 0", {busy, s_ena, way, done});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        int guard = 0;
        fill_din();
        out_cnt = 8'd0; s_valid = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!(way == 3'd5 && im_ena != 8'd0) && guard < 400) begin
            step();
            guard++;
        end
        checks++;
        if (im_ena !== 8'h20) begin
            failures++;
            $display("FAIL abort_reach_way5: got im_ena %h want 20", im_ena);
        end
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({s_ena, im_ena, t_deq, way, busy, done} !== 15'd0 || s_din !== 512'd0) begin
            failures++;
            $display("FAIL abort_zero: got ctrl %h s_din_nz=%b want 0 0",
                     {s_ena, im_ena, t_deq, way, busy, done}, s_din != 512'd0);
        end
        step(); step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_stays_idle: got %b want 0", busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, way} !== {1'b1, 3'd0} || s_din !== exp_batch(0)) begin
            failures++;
            $display("FAIL abort_restart: got busy=%b way=%0d want 1 0", busy, way);
        end
        repeat (12) step();
        checks++;
        if (im_ena !== 8'h01) begin
            failures++;
            $display("FAIL abort_restart_feed: got %h want 01", im_ena);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_rst_drain();
        int guard = 0;
        fill_din();
        out_cnt = 8'd0; s_valid = 1'b1;
        start = 1'b1;
        step();
        while (!t_deq && guard < 400) begin
            step();
            guard++;
        end
        checks++;
        if (t_deq !== 1'b1) begin
            failures++;
            $display("FAIL rst_reach_drain: got %b want 1", t_deq);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({s_ena, im_ena, t_deq, way, busy, done} !== 15'd0 || s_din !== 512'd0) begin
            failures++;
            $display("FAIL rst_drain_zero: got ctrl %h want 0", {s_ena, im_ena, t_deq, way, busy, done});
        end
        step(); step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_restart: got %b want 0", busy);
        end
        rst = 1'b0;
        step();
        start = 1'b0;
        checks++;
        if ({busy, s_ena, way} !== {1'b1, 1'b1, 3'd0}) begin
            failures++;
            $display("FAIL rst_then_start: got %b want 11000", {busy, s_ena, way});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sort_run(-1, 0, 8'd128);
        test_start_held();
        test_sort_run(3, 5, 8'd255);
        test_start_held();
        test_abort();
        test_rst_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
